// File: rtl/am2903_seq_pkg.sv
// ----------------------------------------------------------------------------
// am2903_seq_pkg
//   Shared types and constants for the Am2903/Am2902 multiply sequencer.
//   - seq_state_t : sequencer FSM state encoding
//   - I_*         : 9-bit slice instruction words, I8..I0
//                   (I8..I5 destination / special function,
//                    I4..I1 ALU function, I0 S-source: 0 = RAM B, 1 = Q)
// ----------------------------------------------------------------------------
package am2903_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDQ  = 3'd1,
    S_CLRB = 3'd2,
    S_ITER = 3'd3,
    S_LAST = 3'd4,
    S_DONE = 3'd5
  } seq_state_t;

  // Special functions: I4..I0 = 00000 selects the multiply variants on I8..I5.
  localparam logic [8:0] I_UMUL      = 9'b0000_0000_0;
  localparam logic [8:0] I_TMUL      = 9'b0010_0000_0;
  localparam logic [8:0] I_TMUL_LAST = 9'b0110_0000_0;

  // Destination F->Y,Q ; ALU R plus Cn. With EA_=1 the R operand is DB, so
  // Q is loaded straight from the host-driven multiplier on DB.
  localparam logic [8:0] I_LDQ       = 9'b0110_0110_0;
  // Destination F->Y,RAM ; ALU LOW. Clears RAM[B].
  localparam logic [8:0] I_CLRB      = 9'b0100_1000_0;
  // Destination F->Y only ; ALU S plus Cn with S = RAM B. Shows RAM[B] on Y.
  localparam logic [8:0] I_PASSB     = 9'b1111_0100_0;
  // Harmless idle word; IEN_ is held high whenever this is driven.
  localparam logic [8:0] I_NOP       = 9'b1111_1000_0;

endpackage

// File: rtl/am2903_iter_cnt.sv
// ----------------------------------------------------------------------------
// am2903_iter_cnt
//   Iteration counter for the multiply sequencer. Cleared by i_clr, counts up
//   on i_inc, and flags o_term when the count equals i_term. Counting stops at
//   the terminal value so the register never wraps.
// Ports:
//   i_cp     in   clock, rising edge
//   i_rst_n  in   asynchronous active-low reset
//   i_clr    in   synchronous clear to zero (priority over i_inc)
//   i_inc    in   count enable
//   i_term   in   terminal value, CW bits
//   o_term   out  count == i_term
// ----------------------------------------------------------------------------
module am2903_iter_cnt #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic          i_cp,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_inc,
  input  logic [CW-1:0] i_term,
  output logic          o_term
);

  logic [CW-1:0] r_cnt;
  logic          w_term;

  assign w_term = (r_cnt == i_term);
  assign o_term = w_term;

  always_ff @(posedge i_cp or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_term) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/am2903_mul_seq.sv
// ----------------------------------------------------------------------------
// am2903_mul_seq
//   Sequencer that drives a WIDTH-bit Am2903/Am2902 slice array through a
//   WIDTH x WIDTH multiply using the Am2903 multiply special functions.
//   Multiplicand is pre-loaded in RAM[RA_ADR]; the host drives the multiplier
//   on DB during LDQ. Product high half ends in RAM[RB_ADR], low half in Q.
//   Optional feature: define SIGNED_MUL_EN to honour sgn (two's complement
//   multiply). When undefined, sgn is ignored and the S_LAST state is never
//   entered.
// Ports:
//   cp     in   clock, rising edge
//   rst_   in   asynchronous active-low reset
//   start  in   multiply request
//   sgn    in   1 = two's complement (SIGNED_MUL_EN only)
//   a, b   out  slice RAM A/B addresses
//   i      out  slice instruction I8..I0
//   ien_   out  slice instruction enable (0 = write RAM/Q)
//   ea_    out  slice ALU R-source select (1 = DB)
//   oeb_   out  slice DB output enable (1 = DB is an input)
//   oey_   out  slice Y output enable
//   cn     out  carry into least-significant slice
//   busy   out  sequencer owns the array
//   done   out  one-cycle pulse, product high half on Y
// ----------------------------------------------------------------------------
module am2903_mul_seq
  import am2903_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter logic [3:0]  RA_ADR = 4'h0,
  parameter logic [3:0]  RB_ADR = 4'h1
) (
  input  logic       cp,
  input  logic       rst_,
  input  logic       start,
  input  logic       sgn,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [8:0] i,
  output logic       ien_,
  output logic       ea_,
  output logic       oeb_,
  output logic       oey_,
  output logic       cn,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] C_TERM_U = CW'(WIDTH - 1);
  localparam logic [CW-1:0] C_TERM_S = CW'(WIDTH - 2);

  seq_state_t    r_state;
  seq_state_t    w_next;
  logic          w_mode;
  logic          w_accept;
  logic          w_term;
  logic [CW-1:0] w_term_val;

  // A new multiply is accepted in IDLE, and also in DONE so that a held
  // start strobe chains runs back to back without an idle gap.
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef SIGNED_MUL_EN
  logic r_mode;

  always_ff @(posedge cp or negedge rst_) begin
    if (!rst_) begin
      r_mode <= 1'b0;
    end else if (w_accept) begin
      r_mode <= sgn;
    end
  end

  assign w_mode = r_mode;
`else
  logic w_unused_sgn;

  assign w_unused_sgn = sgn;
  assign w_mode       = 1'b0;
`endif

  assign w_term_val = w_mode ? C_TERM_S : C_TERM_U;

  am2903_iter_cnt #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_cnt (
    .i_cp    (cp),
    .i_rst_n (rst_),
    .i_clr   (r_state == S_CLRB),
    .i_inc   (r_state == S_ITER),
    .i_term  (w_term_val),
    .o_term  (w_term)
  );

  always_ff @(posedge cp or negedge rst_) begin
    if (!rst_) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_LDQ;
      S_LDQ:   w_next = S_CLRB;
      S_CLRB:  w_next = S_ITER;
      S_ITER:  if (w_term) w_next = w_mode ? S_LAST : S_DONE;
      S_LAST:  w_next = S_DONE;
      S_DONE:  w_next = w_accept ? S_LDQ : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Moore output decode; the async state reset forces the idle values
  // (IEN_=1, OEY_=1) in the same instant rst_ falls.
  always_comb begin
    a    = RA_ADR;
    b    = RB_ADR;
    i    = I_NOP;
    ien_ = 1'b1;
    ea_  = 1'b0;
    oeb_ = 1'b1;
    oey_ = 1'b1;
    cn   = 1'b0;
    done = 1'b0;
    busy = (r_state != S_IDLE);
    case (r_state)
      S_LDQ: begin
        i    = I_LDQ;
        ien_ = 1'b0;
        ea_  = 1'b1;
      end
      S_CLRB: begin
        i    = I_CLRB;
        ien_ = 1'b0;
      end
      S_ITER: begin
        i    = w_mode ? I_TMUL : I_UMUL;
        ien_ = 1'b0;
      end
      S_LAST: begin
        i    = I_TMUL_LAST;
        ien_ = 1'b0;
      end
      S_DONE: begin
        i    = I_PASSB;
        oey_ = 1'b0;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_am2903_mul_seq.sv
// ----------------------------------------------------------------------------
// tb_am2903_mul_seq
//   Bench for am2903_mul_seq with a behavioural 16-bit slice-array model.
//   Stimulus pushes hand-computed products into a scoreboard queue; a forked
//   monitor pops and compares on every done pulse.
// ----------------------------------------------------------------------------
module tb_am2903_mul_seq;

  localparam logic [8:0] T_UMUL  = 9'b0000_0000_0;
  localparam logic [8:0] T_TMUL  = 9'b0010_0000_0;
  localparam logic [8:0] T_TLAST = 9'b0110_0000_0;
  localparam logic [8:0] T_LDQ   = 9'b0110_0110_0;
  localparam logic [8:0] T_CLRB  = 9'b0100_1000_0;
  localparam logic [8:0] T_PASSB = 9'b1111_0100_0;
  localparam logic [8:0] T_NOP   = 9'b1111_1000_0;

  logic       cp    = 1'b0;
  logic       rst_  = 1'b0;
  logic       start = 1'b0;
  logic       sgn   = 1'b0;
  logic [3:0] a, b;
  logic [8:0] i;
  logic       ien_, ea_, oeb_, oey_, cn, busy, done;

  am2903_mul_seq #(
    .WIDTH  (16),
    .RA_ADR (4'h0),
    .RB_ADR (4'h1)
  ) dut (
    .cp    (cp),
    .rst_  (rst_),
    .start (start),
    .sgn   (sgn),
    .a     (a),
    .b     (b),
    .i     (i),
    .ien_  (ien_),
    .ea_   (ea_),
    .oeb_  (oeb_),
    .oey_  (oey_),
    .cn    (cn),
    .busy  (busy),
    .done  (done)
  );

  always #5 cp = ~cp;

  // ---------------- slice array model ----------------
  logic [15:0] ram_a = 16'h0;   // RAM[0], pre-loaded by the host
  logic [15:0] ram_b = 16'h0;   // RAM[1]
  logic [15:0] q     = 16'h0;
  logic [15:0] db    = 16'h0;
  logic [15:0] y_bus;
  int unsigned writes  = 0;
  int unsigned bad_ctl = 0;
  int unsigned cyc_cnt = 0;

  function automatic logic [31:0] step(input logic [8:0] op, input logic [15:0] bb, qq, aa);
    logic [16:0] s, addend;
    addend = qq[0] ? {(op != T_UMUL) & aa[15], aa} : 17'd0;
    if (op == T_TLAST)     s = {bb[15], bb} - addend;
    else if (op == T_TMUL) s = {bb[15], bb} + addend;
    else                   s = {1'b0, bb} + addend;
    return {s[16:1], s[0], qq[15:1]};
  endfunction

  function automatic int unsigned ctl_bad(input logic [8:0] op, input logic [3:0] aa, bb,
                                          input logic e, ob, c);
    if (aa != 4'h0 || bb != 4'h1 || c) return 1;
    case (op)
      T_LDQ:                   return (!e || !ob) ? 1 : 0;
      T_CLRB:                  return 0;
      T_UMUL, T_TMUL, T_TLAST: return e ? 1 : 0;
      default:                 return 1;
    endcase
  endfunction

  always @(posedge cp) begin
    cyc_cnt <= cyc_cnt + 1;
    if (rst_ && !ien_) begin
      writes  <= writes + 1;
      bad_ctl <= bad_ctl + ctl_bad(i, a, b, ea_, oeb_, cn);
      case (i)
        T_LDQ:                   q <= db;
        T_CLRB:                  ram_b <= '0;
        T_UMUL, T_TMUL, T_TLAST: {ram_b, q} <= step(i, ram_b, q, ram_a);
        default: ;
      endcase
    end
  end

  assign y_bus = (!oey_ && i == T_PASSB && b == 4'h1) ? ram_b : 16'hxxxx;

  // ---------------- scoreboard / checking ----------------
  typedef struct { logic [15:0] hi; logic [15:0] lo; } exp_t;
  exp_t        exp_q[$];
  int unsigned done_times[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge cp);
      if (rst_ && done === 1'b1) begin
        done_times.push_back(cyc_cnt);
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("result_hi_Y", 32'(y_bus), 32'(e.hi));
          check("result_lo_Q", 32'(q), 32'(e.lo));
        end
      end
    end
  endtask

  task automatic run_mul(input string tag, input logic [15:0] mcand, mplier,
                         input logic s, input logic [15:0] ehi, elo,
                         input int unsigned poke);
    int unsigned cyc;
    bit got;
    @(negedge cp);
    ram_a = mcand; db = mplier; sgn = s; start = 1'b1;
    exp_q.push_back('{ehi, elo});
    @(posedge cp);
    @(negedge cp);
    start = 1'b0; sgn = ~s;   // mode must stay latched
    cyc = 1; got = 1'b0;
    while (cyc < 40 && !got) begin
      if (done) got = 1'b1;
      else begin
        if (cyc == poke) start = 1'b1;
        @(posedge cp);
        @(negedge cp);
        start = 1'b0;
        cyc++;
      end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, cyc, 32'd19);
    @(negedge cp);
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base, wr0, nd0;
    bit prev_done;
    fork monitor(); join_none

    // Reset state
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ien", 32'(ien_), 32'd1);
    check("rst_oey", 32'(oey_), 32'd1);
    check("rst_oeb", 32'(oeb_), 32'd1);
    check("rst_ea", 32'(ea_), 32'd0);
    check("rst_cn", 32'(cn), 32'd0);
    check("rst_i", 32'(i), 32'(T_NOP));
    check("rst_ab", 32'({a, b}), 32'h01);
    @(negedge cp); rst_ = 1'b1;
    repeat (2) @(negedge cp);

    run_mul("u3x5",   16'h0003, 16'h0005, 1'b0, 16'h0000, 16'h000F, 0);
    run_mul("uFFxFF", 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 16'h0001, 0);
`ifdef SIGNED_MUL_EN
    run_mul("s_m3x7", 16'hFFFD, 16'h0007, 1'b1, 16'hFFFF, 16'hFFEB, 0);
`else
    run_mul("sgn_ign", 16'hFFFD, 16'h0007, 1'b1, 16'h0006, 16'hFFEB, 0);
`endif

    // start pulse during busy is ignored
    nd0 = done_times.size();
    run_mul("poke", 16'h0003, 16'h0005, 1'b0, 16'h0000, 16'h000F, 5);
    repeat (25) @(negedge cp);
    check("poke_one_done", done_times.size() - nd0, 32'd1);

    // reset in the middle of ITER
    @(negedge cp);
    ram_a = 16'h1111; db = 16'h2222; start = 1'b1;
    @(posedge cp);
    @(negedge cp); start = 1'b0;
    repeat (6) @(posedge cp);
    #2 rst_ = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ien", 32'(ien_), 32'd1);
    check("midrst_oey", 32'(oey_), 32'd1);
    wr0 = writes; nd0 = done_times.size();
    repeat (3) @(negedge cp);
    rst_ = 1'b1;
    repeat (6) @(negedge cp);
    check("midrst_no_write", writes, wr0);
    check("midrst_idle", 32'(busy), 32'd0);
    check("midrst_no_done", done_times.size(), nd0);

    run_mul("recover", 16'h1234, 16'h0010, 1'b0, 16'h0001, 16'h2340, 0);

    // start held high for 40 cycles: back-to-back runs
    @(negedge cp);
    ram_a = 16'h0003; db = 16'h0005; sgn = 1'b0; start = 1'b1;
    repeat (3) exp_q.push_back('{16'h0000, 16'h000F});
    base = done_times.size();
    prev_done = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge cp);
      if (k == 39) start = 1'b0;
      if (prev_done && k < 40) check("held_ldq_follows", 32'(i), 32'(T_LDQ));
      prev_done = done;
    end
    check("held_done_count", done_times.size() - base, 32'd3);
    if (done_times.size() >= base + 3) begin
      check("held_gap1", done_times[base+1] - done_times[base], 32'd19);
      check("held_gap2", done_times[base+2] - done_times[base+1], 32'd19);
    end

    check("array_ctl_ok", bad_ctl, 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
